// File: rtl/clock_phase_generator.sv
// Four-phase W/X/Y/Z clock sequencer with startup wait, bit-time counter and
// word-aligned halt. Every output is a flop so clock_drivers sees clean levels.
module clock_phase_generator #(
  parameter int DIV       = 4,
  parameter int STARTUP   = 16,
  parameter int BIT_TIMES = 14
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       HALT,
  output logic       CGPP,
  output logic       CGPPN,
  output logic       CGQP,
  output logic       CGQPN,
  output logic       CGRP,
  output logic       CGRPN,
  output logic       BOP,
  output logic [3:0] BT,
  output logic       BT_LAST,
  output logic [1:0] PHASE
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(STARTUP + 1);
  localparam logic [1:0] PH_W = 2'd0, PH_Z = 2'd3;
  localparam logic [3:0] BT_MAX = 4'(BIT_TIMES - 1);

  typedef enum logic [1:0] {S_START, S_RUN, S_STOP} state_t;

  state_t          r_state, w_state_n;
  logic [SW-1:0]   r_scnt, w_scnt_n;
  logic [DW-1:0]   r_div, w_div_n;
  logic [1:0]      r_phase, w_phase_n;
  logic [3:0]      r_bt, w_bt_n;
  logic            r_bop, w_bop_n, r_btl;
  logic            r_p, r_q, r_r, r_pn, r_qn, r_rn;
  logic [2:0]      w_pqr_n;

  // {P,Q,R} per phase: W=100 X=000 Y=101 Z=011
  function automatic logic [2:0] pqr_of(input logic [1:0] ph);
    case (ph)
      2'd0:    pqr_of = 3'b100;
      2'd1:    pqr_of = 3'b000;
      2'd2:    pqr_of = 3'b101;
      default: pqr_of = 3'b011;
    endcase
  endfunction

  always_comb begin
    w_state_n = r_state;
    w_scnt_n  = r_scnt;
    w_div_n   = r_div;
    w_phase_n = r_phase;
    w_bt_n    = r_bt;
    w_bop_n   = r_bop;
    case (r_state)
      S_START: begin
        if (r_scnt == SW'(STARTUP - 1)) begin
          w_state_n = S_RUN;
          w_phase_n = PH_W;
          w_bt_n    = 4'd0;
          w_bop_n   = 1'b1;
          w_div_n   = '0;
        end else begin
          w_scnt_n = r_scnt + SW'(1);
        end
      end
      S_RUN: begin
        if (r_div == DW'(DIV - 1)) begin
          w_div_n = '0;
          if (r_phase == PH_Z) begin
            // HALT only matters on the very last cycle of a word
            if (r_bt == BT_MAX && HALT) begin
              w_state_n = S_STOP;
              w_bop_n   = 1'b0;
            end else begin
              w_phase_n = PH_W;
              w_bt_n    = (r_bt == BT_MAX) ? 4'd0 : r_bt + 4'd1;
            end
          end else begin
            w_phase_n = r_phase + 2'd1;
          end
        end else begin
          w_div_n = r_div + DW'(1);
        end
      end
      S_STOP: begin
        if (!HALT) begin
          w_state_n = S_RUN;
          w_phase_n = PH_W;
          w_bt_n    = 4'd0;
          w_bop_n   = 1'b1;
          w_div_n   = '0;
        end
      end
      default: w_state_n = S_START;
    endcase
  end

  assign w_pqr_n = pqr_of(w_phase_n);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_START;
      r_scnt  <= '0;
      r_div   <= '0;
      r_phase <= PH_Z;
      r_bt    <= BT_MAX;
      r_btl   <= 1'b1;
      r_bop   <= 1'b0;
      r_p     <= 1'b0;
      r_q     <= 1'b1;
      r_r     <= 1'b1;
      r_pn    <= 1'b1;
      r_qn    <= 1'b0;
      r_rn    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_scnt  <= w_scnt_n;
      r_div   <= w_div_n;
      r_phase <= w_phase_n;
      r_bt    <= w_bt_n;
      r_btl   <= (w_bt_n == BT_MAX);
      r_bop   <= w_bop_n;
      r_p     <= w_pqr_n[2];
      r_q     <= w_pqr_n[1];
      r_r     <= w_pqr_n[0];
      r_pn    <= ~w_pqr_n[2];
      r_qn    <= ~w_pqr_n[1];
      r_rn    <= ~w_pqr_n[0];
    end
  end

  assign CGPP    = r_p;
  assign CGPPN   = r_pn;
  assign CGQP    = r_q;
  assign CGQPN   = r_qn;
  assign CGRP    = r_r;
  assign CGRPN   = r_rn;
  assign BOP     = r_bop;
  assign BT      = r_bt;
  assign BT_LAST = r_btl;
  assign PHASE   = r_phase;
endmodule

// File: tb/tb_clock_phase_generator.sv
// Scoreboard bench: driver steps a position-counting model each cycle and queues
// the expected outputs; a monitor pops one entry per clock edge and compares.
module tb_clock_phase_generator;
  localparam int DIV = 4, STARTUP = 16, BT_N = 14;
  localparam int WORD = 4 * DIV * BT_N;

  logic CLK = 1'b0, RSTN = 1'b0, HALT = 1'b0;
  logic CGPP, CGPPN, CGQP, CGQPN, CGRP, CGRPN, BOP, BT_LAST;
  logic [3:0] BT;
  logic [1:0] PHASE;

  clock_phase_generator #(.DIV(DIV), .STARTUP(STARTUP), .BIT_TIMES(BT_N)) dut (
    .CLK(CLK), .RSTN(RSTN), .HALT(HALT),
    .CGPP(CGPP), .CGPPN(CGPPN), .CGQP(CGQP), .CGQPN(CGQPN),
    .CGRP(CGRP), .CGRPN(CGRPN), .BOP(BOP), .BT(BT), .BT_LAST(BT_LAST),
    .PHASE(PHASE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {logic rst; logic [10:0] v;} exp_t;
  exp_t sb[$];
  int errs = 0, nchk = 0;

  // model: 0=startup/reset, 1=running (m_n = cycle within word), 2=stopped
  int m_mode = 0, m_scnt = 0, m_n = 0;

  function automatic logic [2:0] pqr_of(input int ph);
    case (ph)
      0:       pqr_of = 3'b100;
      1:       pqr_of = 3'b000;
      2:       pqr_of = 3'b101;
      default: pqr_of = 3'b011;
    endcase
  endfunction

  function automatic int m_phase();
    m_phase = (m_mode == 1) ? (m_n / DIV) % 4 : 3;
  endfunction

  function automatic int m_bt();
    m_bt = (m_mode == 1) ? m_n / (4 * DIV) : BT_N - 1;
  endfunction

  function automatic logic [10:0] m_vec();
    int ph, bt;
    ph = m_phase();
    bt = m_bt();
    m_vec = {(m_mode == 1), 2'(ph), pqr_of(ph), 4'(bt), (bt == BT_N - 1)};
  endfunction

  task automatic cyc(input logic h, input logic rn);
    @(negedge CLK);
    HALT = h;
    RSTN = rn;
    if (!rn) begin
      m_mode = 0;
      m_scnt = 0;
      #1;
      nchk++;
      if (BOP !== 1'b0 || PHASE !== 2'd3 || BT !== 4'(BT_N - 1)) begin
        errs++;
        $display("FAIL async_reset: got bop=%b phase=%0d bt=%0d, want bop=0 phase=3 bt=%0d",
                 BOP, PHASE, BT, BT_N - 1);
      end
    end else begin
      case (m_mode)
        0: if (m_scnt == STARTUP - 1) begin m_mode = 1; m_n = 0; end
           else m_scnt++;
        1: if (m_n == WORD - 1) begin
             if (h) m_mode = 2;
             else m_n = 0;
           end else m_n++;
        default: if (!h) begin m_mode = 1; m_n = 0; end
      endcase
    end
    sb.push_back('{rst: !rn, v: m_vec()});
  endtask

  // ph/sub are phase and divider offset; bt<0 means any bit time
  task automatic wait_pos(input int bt, input int ph, input int sub);
    for (int i = 0; i < 3 * WORD; i++) begin
      if (m_mode == 1 && (bt < 0 || m_bt() == bt) && m_phase() == ph && m_n % DIV == sub)
        return;
      cyc(1'b0, 1'b1);
    end
    nchk++;
    errs++;
    $display("FAIL wait_pos: position bt=%0d ph=%0d not reached, want reached", bt, ph);
  endtask

  initial begin : monitor
    exp_t e;
    logic [10:0] d;
    logic prst;
    logic [1:0] pph;
    logic pp, pq, pr;
    int nqr;
    prst = 1'b1;
    pph = 2'd3; pp = 1'b0; pq = 1'b1; pr = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        d = {BOP, PHASE, CGPP, CGQP, CGRP, BT, BT_LAST};
        nchk++;
        if (d !== e.v) begin
          errs++;
          $display("FAIL outputs t=%0t: got {bop,ph,pqr,bt,last}=%b_%0d_%b_%0d_%b want %b_%0d_%b_%0d_%b",
                   $time, d[10], d[9:8], d[7:5], d[4:1], d[0],
                   e.v[10], e.v[9:8], e.v[7:5], e.v[4:1], e.v[0]);
        end
        nchk++;
        if ({CGPPN, CGQPN, CGRPN} !== ~{CGPP, CGQP, CGRP}) begin
          errs++;
          $display("FAIL complement: got n=%b p=%b want n=%b",
                   {CGPPN, CGQPN, CGRPN}, {CGPP, CGQP, CGRP}, ~{CGPP, CGQP, CGRP});
        end
        if (!e.rst && !prst && PHASE != pph) begin
          nchk++;
          if (CGPP === pp) begin
            errs++;
            $display("FAIL p_toggle: P=%b at phase entry %0d, want %b", CGPP, PHASE, ~pp);
          end
          // the encoding table makes Z->W flip both Q and R, so only other entries are limited
          if (!(pph == 2'd3 && PHASE == 2'd0)) begin
            nqr = int'(CGQP !== pq) + int'(CGRP !== pr);
            nchk++;
            if (nqr > 1) begin
              errs++;
              $display("FAIL qr_changes: %0d of Q/R changed entering %0d, want <=1", nqr, PHASE);
            end
          end
        end
        prst = e.rst;
        pph = PHASE; pp = CGPP; pq = CGQP; pr = CGRP;
      end
    end
  end

  initial begin : stim
    int n;
    repeat (3) cyc(1'b0, 1'b0);
    // startup then two-plus free-running words
    repeat (STARTUP + 2 * WORD + 20) cyc(1'b0, 1'b1);

    // halt requested mid-word: word completes, then stops at Z
    wait_pos(5, 1, 0);
    for (int i = 0; i < 2 * WORD && m_mode != 2; i++) cyc(1'b1, 1'b1);
    n = $urandom_range(2, 9);
    repeat (n) cyc(1'b1, 1'b1);
    repeat (3 * DIV * 4) cyc(1'b0, 1'b1);

    // one-cycle halt pulse away from the boundary is ignored
    wait_pos(7, 2, 1);
    cyc(1'b1, 1'b1);
    repeat (WORD) cyc(1'b0, 1'b1);

    // random halt noise and random-length halt windows
    repeat (1500) cyc(($urandom % 6) == 0, 1'b1);
    repeat (6) begin
      n = $urandom_range(10, 300);
      repeat (n) cyc(1'b0, 1'b1);
      n = $urandom_range(10, 300);
      repeat (n) cyc(1'b1, 1'b1);
    end
    repeat (40) cyc(1'b0, 1'b1);

    // reset pulse mid-phase Y, then full startup again
    wait_pos(-1, 2, 1);
    cyc(1'b0, 1'b0);
    repeat (STARTUP + WORD + 10) cyc(1'b0, 1'b1);

    repeat (3) @(posedge CLK);
    #2;
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
